// File: rtl/player1text_sprite_fetch_if.sv
// Sprite ROM bus for player1text_sprite_fetch: registered address out, 4-bit data back
// one cycle later.
interface player1text_sprite_fetch_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_q;

    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/player1text_sprite_fetch.sv
// Player-1 text sprite fetch: window detect, ROM addressing, 3-cycle pixel pipe and a
// frame-synchronous show/blink FSM. Define P1TEXT_BLINK_EN to build the blink states.
module player1text_sprite_fetch #(
    parameter int         X_POS           = 240,
    parameter int         Y_POS           = 16,
    parameter int         IMG_W           = 160,
    parameter int         IMG_H           = 32,
    parameter int         ADDR_W          = 13,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0,
    parameter int         HALF_PERIOD     = 15,
    parameter int         BLINK_TOGGLES   = 6
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic [9:0]                 draw_x,
    input  logic [9:0]                 draw_y,
    input  logic                       active,
    input  logic                       frame_tick,
    input  logic                       show,
    input  logic                       blink_req,
    player1text_sprite_fetch_if.master rom,
    output logic [3:0]                 pix_idx,
    output logic                       pix_valid,
    output logic                       blinking
);

    typedef enum logic [1:0] {
        HIDDEN    = 2'd0,
        SHOWN     = 2'd1,
        BLINK_ON  = 2'd2,
        BLINK_OFF = 2'd3
    } state_t;

    // Window bounds held at 11 bits so X_POS+IMG_W up to 1023 cannot wrap.
    localparam logic [10:0] X_LO = 11'(X_POS);
    localparam logic [10:0] X_HI = 11'(X_POS + IMG_W);
    localparam logic [10:0] Y_LO = 11'(Y_POS);
    localparam logic [10:0] Y_HI = 11'(Y_POS + IMG_H);
    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

    logic [10:0]       x_s;
    logic [10:0]       y_s;
    logic [10:0]       col_off_s;
    logic [10:0]       row_off_s;
    logic [ADDR_W-1:0] addr_s;
    logic              hit_s;
    logic [ADDR_W-1:0] rom_addr_r;
    logic              hit_d1_r;
    logic              hit_d2_r;
    logic [3:0]        pix_idx_r;
    logic              pix_valid_r;
    logic              visible_s;
    state_t            state_r;
    state_t            state_n;

    assign x_s       = {1'b0, draw_x};
    assign y_s       = {1'b0, draw_y};
    assign col_off_s = x_s - X_LO;
    assign row_off_s = y_s - Y_LO;
    assign hit_s     = active && (x_s >= X_LO) && (x_s < X_HI) && (y_s >= Y_LO) && (y_s < Y_HI);
    // Address arithmetic done modulo 2^ADDR_W, which equals truncating the full product.
    assign addr_s    = ADDR_W'(row_off_s) * W_A + ADDR_W'(col_off_s);

    // Stage 1: register ROM address and window hit.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r <= {ADDR_W{1'b0}};
            hit_d1_r   <= 1'b0;
        end else begin
            rom_addr_r <= hit_s ? addr_s : {ADDR_W{1'b0}};
            hit_d1_r   <= hit_s;
        end
    end

    assign rom.rom_addr = rom_addr_r;

    // Stage 2: carry the hit flag alongside the ROM read.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_d2_r <= 1'b0;
        end else begin
            hit_d2_r <= hit_d1_r;
        end
    end

    // Stage 3: palette index and opaque/visible flag.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_idx_r   <= TRANSPARENT_IDX;
            pix_valid_r <= 1'b0;
        end else begin
            pix_idx_r   <= hit_d2_r ? rom.rom_q : TRANSPARENT_IDX;
            pix_valid_r <= hit_d2_r && (rom.rom_q != TRANSPARENT_IDX) && visible_s;
        end
    end

    assign pix_idx   = pix_idx_r;
    assign pix_valid = pix_valid_r;

`ifdef P1TEXT_BLINK_EN
    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int TG_W = $clog2(BLINK_TOGGLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [TG_W-1:0] TG_LAST = TG_W'(BLINK_TOGGLES - 1);

    logic            pend_r;
    logic            pend_eff_s;
    logic [PH_W-1:0] phase_r;
    logic [PH_W-1:0] phase_n;
    logic [TG_W-1:0] tog_r;
    logic [TG_W-1:0] tog_n;
    logic            blink_n_s;
    logic            blinking_r;

    // A request coinciding with the tick is honoured at that tick.
    assign pend_eff_s = pend_r | blink_req;

    // Pending blink request, consumed at every frame tick.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r <= 1'b0;
        end else if (frame_tick) begin
            pend_r <= 1'b0;
        end else if (blink_req) begin
            pend_r <= 1'b1;
        end else begin
            pend_r <= pend_r;
        end
    end

    // FSM state register, burst counters and registered blinking flag.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= HIDDEN;
            phase_r    <= {PH_W{1'b0}};
            tog_r      <= {TG_W{1'b0}};
            blinking_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            phase_r    <= phase_n;
            tog_r      <= tog_n;
            blinking_r <= blink_n_s;
        end
    end

    // Next-state logic; only a frame tick moves the FSM.
    always_comb begin
        state_n = state_r;
        phase_n = phase_r;
        tog_n   = tog_r;
        if (frame_tick) begin
            case (state_r)
                HIDDEN: begin
                    if (show) begin
                        state_n = pend_eff_s ? BLINK_ON : SHOWN;
                        phase_n = {PH_W{1'b0}};
                        tog_n   = {TG_W{1'b0}};
                    end else begin
                        state_n = HIDDEN;
                    end
                end
                SHOWN: begin
                    if (!show) begin
                        state_n = HIDDEN;
                    end else if (pend_eff_s) begin
                        state_n = BLINK_ON;
                        phase_n = {PH_W{1'b0}};
                        tog_n   = {TG_W{1'b0}};
                    end else begin
                        state_n = SHOWN;
                    end
                end
                BLINK_ON, BLINK_OFF: begin
                    if (!show) begin
                        state_n = HIDDEN;
                        phase_n = {PH_W{1'b0}};
                        tog_n   = {TG_W{1'b0}};
                    end else if (pend_eff_s) begin
                        state_n = BLINK_ON;
                        phase_n = {PH_W{1'b0}};
                        tog_n   = {TG_W{1'b0}};
                    end else if (phase_r == PH_LAST) begin
                        phase_n = {PH_W{1'b0}};
                        tog_n   = tog_r + TG_W'(1);
                        if (tog_r == TG_LAST) begin
                            state_n = SHOWN;
                        end else begin
                            state_n = (state_r == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        end
                    end else begin
                        phase_n = phase_r + PH_W'(1);
                        state_n = state_r;
                    end
                end
                default: begin
                    state_n = HIDDEN;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM outputs: visibility from the current state, blinking from the next.
    always_comb begin
        visible_s = 1'b0;
        blink_n_s = 1'b0;
        case (state_r)
            SHOWN:    visible_s = 1'b1;
            BLINK_ON: visible_s = 1'b1;
            default:  visible_s = 1'b0;
        endcase
        case (state_n)
            BLINK_ON, BLINK_OFF: blink_n_s = 1'b1;
            default:             blink_n_s = 1'b0;
        endcase
    end

    assign blinking = blinking_r;
`else
    logic unused_blink_s;

    assign unused_blink_s = blink_req;

    // FSM state register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HIDDEN;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; only a frame tick moves the FSM.
    always_comb begin
        state_n = state_r;
        if (frame_tick) begin
            case (state_r)
                HIDDEN:  state_n = show ? SHOWN : HIDDEN;
                SHOWN:   state_n = show ? SHOWN : HIDDEN;
                default: state_n = HIDDEN;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM outputs.
    always_comb begin
        visible_s = 1'b0;
        case (state_r)
            SHOWN:   visible_s = 1'b1;
            default: visible_s = 1'b0;
        endcase
    end

    assign blinking = 1'b0;
`endif

endmodule

// File: tb/tb_player1text_sprite_fetch.sv
// Randomised and directed bench for player1text_sprite_fetch against a per-pixel /
// per-frame reference model.
module tb_player1text_sprite_fetch;

    localparam int X_POS  = 240;
    localparam int Y_POS  = 16;
    localparam int IMG_W  = 160;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 13;
    localparam int HP     = 15;
    localparam int TOG    = 6;
`ifdef P1TEXT_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       active;
    logic       frame_tick;
    logic       show;
    logic       blink_req;
    logic [3:0] pix_idx;
    logic       pix_valid;
    logic       blinking;

    int unsigned rom_mode = 0;
    int errors = 0;
    int checks = 0;

    // Reference model state: display mode (0 hidden, 1 shown, 2 burst) and frames into burst.
    int unsigned m_mode;
    int unsigned m_bf;
    bit          m_pend;
    bit          d1_hit;
    int unsigned d1_addr;
    bit          d2_hit;
    logic [3:0]  d2_idx;
    logic [3:0]  e_idx;
    bit          e_valid;
    int unsigned e_addr;
    bit          e_blink;

    player1text_sprite_fetch_if #(.ADDR_W(ADDR_W)) rom_if ();

    player1text_sprite_fetch #(
        .X_POS(X_POS), .Y_POS(Y_POS), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .TRANSPARENT_IDX(4'h0), .HALF_PERIOD(HP), .BLINK_TOGGLES(TOG)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .active(active), .frame_tick(frame_tick), .show(show), .blink_req(blink_req),
        .rom(rom_if.master), .pix_idx(pix_idx), .pix_valid(pix_valid), .blinking(blinking)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_fn(input int unsigned mode, input int unsigned addr);
        case (mode)
            0:       return 4'(addr + 1);
            1:       return 4'h0;
            2:       return 4'hA;
            default: return 4'((addr * 7 + 3) ^ (addr >> 4));
        endcase
    endfunction

    always @(posedge vga_clk) rom_if.rom_q <= rom_fn(rom_mode, int'(rom_if.rom_addr));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_bf = 0; m_pend = 1'b0;
        d1_hit = 1'b0; d1_addr = 0; d2_hit = 1'b0; d2_idx = 4'h0;
    endtask

    // One clock: model the edge using the held inputs, then compare settled outputs.
    task automatic step();
        int unsigned x;
        int unsigned y;
        bit vis;
        bit pe;
        @(posedge vga_clk);
        x = draw_x; y = draw_y;
        vis = (m_mode == 1) || (m_mode == 2 && ((m_bf / HP) % 2 == 0));
        e_idx   = d2_hit ? d2_idx : 4'h0;
        e_valid = d2_hit && (d2_idx != 4'h0) && vis;
        d2_hit  = d1_hit;
        d2_idx  = rom_fn(rom_mode, d1_addr);
        d1_hit  = active && x >= X_POS && x < X_POS + IMG_W && y >= Y_POS && y < Y_POS + IMG_H;
        d1_addr = d1_hit ? ((y - Y_POS) * IMG_W + (x - X_POS)) % (1 << ADDR_W) : 0;
        e_addr  = d1_addr;
        if (frame_tick) begin
            pe = BLINK_EN && (m_pend || blink_req);
            m_pend = 1'b0;
            if (!show) m_mode = 0;
            else if (pe) begin m_mode = 2; m_bf = 0; end
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 2) begin
                m_bf++;
                if (m_bf == HP * TOG) m_mode = 1;
            end
        end else if (blink_req && BLINK_EN) begin
            m_pend = 1'b1;
        end
        e_blink = (m_mode == 2);
        #1;
        check_val("pix_idx", 32'(pix_idx), 32'(e_idx));
        check_val("pix_valid", 32'(pix_valid), 32'(e_valid));
        check_val("rom_addr", 32'(rom_if.rom_addr), e_addr);
        check_val("blinking", 32'(blinking), 32'(e_blink));
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_pix_idx", 32'(pix_idx), 32'h0);
        check_val("rst_pix_valid", 32'(pix_valid), 32'h0);
        check_val("rst_rom_addr", 32'(rom_if.rom_addr), 32'h0);
        check_val("rst_blinking", 32'(blinking), 32'h0);
        repeat (cycles) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_px(input int unsigned x, input int unsigned y, input bit act);
        draw_x = 10'(x); draw_y = 10'(y); active = act;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; draw_x = 10'd0; draw_y = 10'd0; active = 1'b0;
        frame_tick = 1'b0; show = 1'b0; blink_req = 1'b0;
        model_reset();
        #3;
        do_reset(2);

        // Window edges with ROM = address[3:0]+1.
        show = 1'b1;
        tick();
        rom_mode = 0;
        for (int y = 15; y <= 48; y++) begin
            for (int x = 230; x <= 410; x++) begin
                set_px(x, y, 1'b1);
                step();
            end
        end
        set_px(0, 0, 1'b0);
        repeat (4) step();

        // Directed address points.
        set_px(241, 17, 1'b1); step();
        check_val("addr_241_17", 32'(rom_if.rom_addr), 32'd161);
        set_px(399, 47, 1'b1); step();
        check_val("addr_399_47", 32'(rom_if.rom_addr), 32'd5119);
        set_px(400, 47, 1'b1); step();
        check_val("addr_400_47", 32'(rom_if.rom_addr), 32'd0);
        set_px(300, 48, 1'b1); step();
        check_val("addr_row48", 32'(rom_if.rom_addr), 32'd0);

        // Transparency then opaque.
        rom_mode = 1;
        set_px(300, 20, 1'b1);
        repeat (4) step();
        check_val("transp_valid", 32'(pix_valid), 32'd0);
        check_val("transp_idx", 32'(pix_idx), 32'd0);
        rom_mode = 2;
        repeat (4) step();
        check_val("opaque_valid", 32'(pix_valid), 32'd1);
        check_val("opaque_idx", 32'(pix_idx), 32'hA);

        // Blink burst: request, then 100 ticks with an opaque pixel between ticks.
        blink_req = 1'b1; step(); blink_req = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick();
            step(); step(); step();
        end
        check_val("burst_done_blinking", 32'(blinking), 32'd0);
        check_val("burst_done_visible", 32'(pix_valid), 32'd1);

        // Request coinciding with a tick, then abort with show=0.
        blink_req = 1'b1; frame_tick = 1'b1; step();
        blink_req = 1'b0; frame_tick = 1'b0;
        check_val("simul_blinking", 32'(blinking), 32'(BLINK_EN));
        repeat (3) begin tick(); step(); end
        show = 1'b0; step(); step();
        check_val("abort_wait_blinking", 32'(blinking), 32'(BLINK_EN));
        tick();
        check_val("abort_blinking", 32'(blinking), 32'd0);
        repeat (4) step();
        check_val("abort_hidden", 32'(pix_valid), 32'd0);

        // Reset during the OFF phase of a burst.
        show = 1'b1;
        blink_req = 1'b1; tick(); blink_req = 1'b0;
        repeat (20) begin tick(); step(); end
        do_reset(2);
        repeat (6) step();
        check_val("post_rst_hidden", 32'(pix_valid), 32'd0);
        tick();
        repeat (4) step();
        check_val("post_rst_shown", 32'(pix_valid), 32'd1);

        // Randomised traffic.
        rom_mode = 3;
        for (int c = 0; c < 5000; c++) begin
            set_px($urandom_range(230, 410), $urandom_range(10, 55), $urandom_range(0, 7) != 0);
            frame_tick = (c % 23 == 0);
            if (frame_tick && $urandom_range(0, 9) == 0) show = ~show;
            blink_req = ($urandom_range(0, 60) == 0);
            step();
        end
        frame_tick = 1'b0; blink_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player1text_sprite_fetch.md
# player1text_sprite_fetch

Upstream feeder for the player-1 text palette stage. From the VGA scan coordinates it detects the text sprite window, drives the sprite ROM address, and aligns the returned 4-bit palette index with a valid flag. It also runs a frame-synchronous show/blink state machine, so the banner can appear, disappear or flash without tearing. Downstream, the palette maps `pix_idx` to RGB, and the colour mux uses `pix_valid` to choose sprite over background.

## Interface
- `X_POS`, 240: left column of the sprite window.
- `Y_POS`, 16: top row of the sprite window.
- `IMG_W`, 160: sprite width in pixels.
- `IMG_H`, 32: sprite height in pixels.
- `ADDR_W`, 13: ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `TRANSPARENT_IDX`, 4'h0: palette index treated as see-through.
- `HALF_PERIOD`, 15: frames per blink phase.
- `BLINK_TOGGLES`, 6: phase changes per blink burst.
- `vga_clk`, in, 1: pixel clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `draw_x`, in, 10: current scan column.
- `draw_y`, in, 10: current scan row.
- `active`, in, 1: display-enable for the current pixel.
- `frame_tick`, in, 1: one-cycle pulse, once per frame, during vblank.
- `show`, in, 1: level; the banner is requested.
- `blink_req`, in, 1: one-cycle pulse; request a blink burst.
- `rom_addr`, out, ADDR_W: address to a synchronous 1-cycle-latency sprite ROM.
- `rom_q`, in, 4: ROM data; valid the cycle after `rom_addr`.
- `pix_idx`, out, 4: palette index sent to the palette stage.
- `pix_valid`, out, 1: the sprite pixel is opaque and visible.
- `blinking`, out, 1: the FSM is in a blink state.

## Operation
- Stage 1 (registered):
  - `hit = active && draw_x ≥ X_POS && draw_x < X_POS+IMG_W && draw_y ≥ Y_POS && draw_y < Y_POS+IMG_H`.
  - All comparisons use 11-bit unsigned arithmetic, so `X_POS+IMG_W` up to 1023 cannot overflow.
  - `rom_addr = (draw_y−Y_POS)*IMG_W + (draw_x−X_POS)`, truncated to ADDR_W bits, when `hit`; otherwise `rom_addr` = 0.
  - `hit` is piped forward as `hit_d1`.
- Stage 2: the ROM returns `rom_q`; `hit_d1` is piped to `hit_d2`.
- Stage 3 (registered):
  - `pix_idx = hit_d2 ? rom_q : TRANSPARENT_IDX`.
  - `pix_valid = hit_d2 && rom_q ≠ TRANSPARENT_IDX && visible`.
- `visible` is 1 in SHOWN or BLINK_ON.
- FSM states are HIDDEN, SHOWN, BLINK_ON and BLINK_OFF. State changes only on `frame_tick`.
- `blink_req` sets `pend`. At every `frame_tick`, `pend` is consumed and cleared. A `blink_req` in the same cycle as `frame_tick` counts as pending for that tick.
- HIDDEN:
  - `show=1` at tick → SHOWN, or BLINK_ON if `pend` is set.
  - `pend` with `show=0` is discarded.
- SHOWN:
  - `show=0` at tick → HIDDEN.
  - `pend` at tick → BLINK_ON, `phase_cnt`=0, `tog_cnt`=0.
- BLINK_ON / BLINK_OFF:
  - `show=0` at tick → HIDDEN. This has priority over everything else.
  - Otherwise `phase_cnt` increments. When it reaches HALF_PERIOD−1 it wraps to 0, the state flips, and `tog_cnt` increments.
  - When `tog_cnt` reaches BLINK_TOGGLES the state → SHOWN, regardless of the ON/OFF phase.
  - A `pend` during a burst restarts both counters and enters BLINK_ON.
- `blinking` = state ∈ {BLINK_ON, BLINK_OFF}.

## Timing
- Latency from `draw_x`/`draw_y` to `pix_idx`/`pix_valid` is exactly 3 cycles. The downstream sync delay must match.
- `rom_addr` changes 1 cycle after the coordinates are presented.
- Visibility changes only at frame boundaries. No change in visibility ever occurs mid-frame.
- `pix_valid` sees the new `visible` value from the cycle after `frame_tick`.
- Reset values (asserted asynchronously; released synchronously to `vga_clk` by the top level):
  - `rom_addr`=0, `pix_idx`=TRANSPARENT_IDX, `pix_valid`=0, `blinking`=0.
  - State HIDDEN, `pend`=0, all counters 0, pipeline hit flags 0.
- Reset mid-frame or mid-burst drops the burst entirely. It does not resume after release.

## Configuration
- `P1TEXT_BLINK_EN` defined: full four-state FSM, `blink_req` honoured.
- `P1TEXT_BLINK_EN` undefined:
  - Only HIDDEN and SHOWN exist. `blink_req` is ignored, and `pend` and the counters are removed.
  - `blinking` is tied to 0.
  - The pipeline is unchanged.

## Test plan
- **Window edges:** reset, `show=1`, one tick, then scan rows 15–48 with ROM = address[3:0]+1.
  - `pix_valid` first rises 3 cycles after (240,16).
  - `pix_valid` falls 3 cycles after (399,47).
  - Row 48 and column 400 produce none.
- **Address:** (241,17) → `rom_addr`=161 one cycle later. (399,47) → 5119. Outside the window `rom_addr`=0.
- **Transparency:** ROM returns 4'h0 inside the window → `pix_idx`=0, `pix_valid`=0. ROM returns 4'hA → `pix_valid`=1, `pix_idx`=4'hA.
- **Blink burst:** `show=1`, `blink_req`, then 100 ticks with HALF_PERIOD=15 and BLINK_TOGGLES=6.
  - Visible for 15 frames, hidden for 15, and so on for 6 phases.
  - Then SHOWN at frame 90, with `blinking` = 0.
- **Simultaneous and abort:** `blink_req` in the same cycle as `frame_tick` → BLINK_ON next cycle. `show=0` mid-burst → HIDDEN at the next tick.
- **Reset mid-burst:** `reset_n` low for 2 cycles during BLINK_OFF → all outputs at reset values immediately. After release the FSM is HIDDEN until the next tick.
